snes_poll_scheduler: RTL and testbench

Single-clock sequencer that owns the shared SNES serial interface (common clock/latch, two data lines). It arbitrates between two poll requesters, a free-running auto-poll timer and a CPU-issued one-shot request, and runs one latch-plus-16-bit shift transaction at a time. It publishes both controller words atomically to the CPU register file and raises a change interrupt. It sits between the CPU I/O decode and the SNES connector pins.

---
 rtl/snes_poll_scheduler_pkg.sv | 17 +
 rtl/snes_tick_gen.sv | 28 ++
 rtl/snes_poll_scheduler.sv | 152 +++++++++++++++
 tb/tb_snes_poll_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_poll_scheduler_pkg.sv
// Shared definitions for the SNES controller poll scheduler: sequencer states
// and the word geometry of one controller read.
package snes_poll_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        LOW,
        HIGH,
        DONE
    } snes_state_e;

    localparam int          SNES_NUM_BITS  = 16;
    localparam logic [15:0] SNES_IDLE_WORD = 16'hFFFF;

endpackage

// File: rtl/snes_tick_gen.sv
// Modulo-N cycle counter producing a one-cycle strobe every N cycles.
// Holding restart keeps the count at zero and suppresses the strobe.
module snes_tick_gen #(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] count;

    assign tick = (count == W'(N - 1)) && !restart;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/snes_poll_scheduler.sv
// Owns the shared SNES serial port: merges auto and CPU poll requests, runs one
// latch + 16-bit shift at a time and publishes both words atomically.
module snes_poll_scheduler
    import snes_poll_scheduler_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ        = 25000000,
    parameter int SNES_CLOCK_FREQ_HZ   = 100000,
    parameter int SNES_POLLING_FREQ_HZ = 1000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        auto_en,
    input  logic        poll_req,
    input  logic        irq_ack,
    input  logic        snes1_data,
    input  logic        snes2_data,
    output logic        snes_clock,
    output logic        snes_latch,
    output logic [15:0] joy1_data,
    output logic [15:0] joy2_data,
    output logic        data_valid,
    output logic        busy,
    output logic        change_irq
);

    localparam int H = CLOCK_FREQ_HZ / (2 * SNES_CLOCK_FREQ_HZ);
    localparam int P = CLOCK_FREQ_HZ / SNES_POLLING_FREQ_HZ;

    if (H < 2) begin : g_bad_half_period
        $error("snes_poll_scheduler: half period H=%0d must be at least 2", H);
    end
    if (P <= 40 * H) begin : g_bad_poll_interval
        $error("snes_poll_scheduler: poll interval P=%0d must exceed 40*H", P);
    end

    snes_state_e              state, state_next;
    logic [3:0]               bit_idx, bit_idx_next;
    logic                     latch_second, latch_second_next;
    logic                     pending, pending_clr;
    logic                     sample_en, publish;
    logic                     half_tick, poll_tick, poll_set;
    logic                     word_changed;
    logic [SNES_NUM_BITS-1:0] shadow1, shadow2;

    // Half-period timer is held at zero in IDLE so every transaction starts phase-aligned.
    snes_tick_gen #(.N(H)) u_half_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (state == IDLE),
        .tick    (half_tick)
    );

    snes_tick_gen #(.N(P)) u_poll_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (1'b0),
        .tick    (poll_tick)
    );

    assign poll_set     = poll_req || (auto_en && poll_tick);
    assign word_changed = (shadow1 != joy1_data) || (shadow2 != joy2_data);

    assign snes_latch = (state == LATCH);
    assign snes_clock = (state != LOW);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next        = state;
        bit_idx_next      = bit_idx;
        latch_second_next = latch_second;
        pending_clr       = 1'b0;
        sample_en         = 1'b0;
        publish           = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    pending_clr       = 1'b1;
                    latch_second_next = 1'b0;
                    state_next        = LATCH;
                end
            end
            LATCH: begin
                if (half_tick) begin
                    latch_second_next = !latch_second;
                    if (latch_second) state_next = GAP;
                end
            end
            GAP: begin
                if (half_tick) begin
                    bit_idx_next = '0;
                    sample_en    = 1'b1;
                    state_next   = LOW;
                end
            end
            LOW: begin
                if (half_tick) state_next = HIGH;
            end
            HIGH: begin
                if (half_tick) begin
                    if (bit_idx != 4'(SNES_NUM_BITS - 1)) begin
                        bit_idx_next = bit_idx + 1'b1;
                        sample_en    = 1'b1;
                        state_next   = LOW;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                publish    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_idx      <= '0;
            latch_second <= 1'b0;
            pending      <= 1'b0;
            shadow1      <= SNES_IDLE_WORD;
            shadow2      <= SNES_IDLE_WORD;
            joy1_data    <= SNES_IDLE_WORD;
            joy2_data    <= SNES_IDLE_WORD;
            data_valid   <= 1'b0;
            change_irq   <= 1'b0;
        end else begin
            state        <= state_next;
            bit_idx      <= bit_idx_next;
            latch_second <= latch_second_next;
            // A request landing on the accept cycle is kept, not swallowed.
            pending      <= poll_set || (pending && !pending_clr);
            if (sample_en) begin
                shadow1[bit_idx_next] <= snes1_data;
                shadow2[bit_idx_next] <= snes2_data;
            end
            if (publish) begin
                joy1_data  <= shadow1;
                joy2_data  <= shadow2;
                data_valid <= 1'b1;
            end
            if (publish && word_changed) begin
                change_irq <= 1'b1;
            end else if (irq_ack) begin
                change_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snes_poll_scheduler.sv
// Bench for snes_poll_scheduler with H=4 and P=200: behavioural controller
// models on both data lines and a queue of expected published words.
module tb_snes_poll_scheduler;

    localparam int H   = 4;
    localparam int P   = 200;
    localparam int TXN = 35 * H + 1;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        logic        irq;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        auto_en = 1'b0;
    logic        poll_req = 1'b0;
    logic        irq_ack = 1'b0;
    logic        snes1_data, snes2_data;
    logic        snes_clock, snes_latch;
    logic [15:0] joy1_data, joy2_data;
    logic        data_valid, busy, change_irq;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ctrl1_word = 16'hFFFF;
    logic [15:0] ctrl2_word = 16'hFFFF;
    logic [15:0] m_joy1 = 16'hFFFF;
    logic [15:0] m_joy2 = 16'hFFFF;
    logic        m_irq = 1'b0;
    exp_t        sb_q[$];

    snes_poll_scheduler #(
        .CLOCK_FREQ_HZ        (800),
        .SNES_CLOCK_FREQ_HZ   (100),
        .SNES_POLLING_FREQ_HZ (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .auto_en    (auto_en),
        .poll_req   (poll_req),
        .irq_ack    (irq_ack),
        .snes1_data (snes1_data),
        .snes2_data (snes2_data),
        .snes_clock (snes_clock),
        .snes_latch (snes_latch),
        .joy1_data  (joy1_data),
        .joy2_data  (joy2_data),
        .data_valid (data_valid),
        .busy       (busy),
        .change_irq (change_irq)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Controller model: parallel load while latch is high, next bit after each rising clock.
    logic       prev_clk = 1'b1;
    logic       prev_latch = 1'b0;
    logic [4:0] pos = 5'd0;
    int         falls = 0;
    int         latch_hi = 0;
    int         rise_q[$];

    assign snes1_data = (pos < 5'd16) ? ctrl1_word[pos[3:0]] : 1'b1;
    assign snes2_data = (pos < 5'd16) ? ctrl2_word[pos[3:0]] : 1'b1;

    always @(negedge clock) begin
        if (!prev_latch && snes_latch) rise_q.push_back(cyc);
        if (prev_clk && !snes_clock) falls <= falls + 1;
        if (snes_latch) latch_hi <= latch_hi + 1;
        if (snes_latch) pos <= 5'd0;
        else if (!prev_clk && snes_clock && pos < 5'd16) pos <= pos + 5'd1;
        prev_clk   <= snes_clock;
        prev_latch <= snes_latch;
    end

    task automatic start_poll(input logic [15:0] w1, input logic [15:0] w2);
        exp_t e;
        ctrl1_word = w1;
        ctrl2_word = w2;
        e.j1  = w1;
        e.j2  = w2;
        e.irq = m_irq | (w1 != m_joy1) | (w2 != m_joy2);
        m_joy1 = w1;
        m_joy2 = w2;
        m_irq  = e.irq;
        sb_q.push_back(e);
        @(negedge clock);
        poll_req = 1'b1;
        @(negedge clock);
        poll_req = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge clock);
        poll_req = 1'b1;
        @(negedge clock);
        poll_req = 1'b0;
    endtask

    task automatic ack_irq();
        @(negedge clock);
        irq_ack = 1'b1;
        m_irq   = 1'b0;
        @(negedge clock);
        irq_ack = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic wait_rise(input int idx, output int c);
        int budget = 1000;
        while (rise_q.size() <= idx && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (rise_q.size() > idx) begin
            c = rise_q[idx];
        end else begin
            c = -100000;
            vectors++;
            miscompares++;
            $display("FAIL latch_rise_timeout got none required rise #%0d", idx);
        end
    endtask

    task automatic wait_idle(input string name);
        int budget = 2000;
        bit seen = 0;
        bit done = 0;
        while (!done && budget > 0) begin
            @(negedge clock);
            budget--;
            if (busy) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_idle_timeout got busy=%b required busy to fall", name, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({snes_clock, snes_latch, joy1_data, joy2_data, data_valid, busy, change_irq} !==
            {1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got clk=%b lat=%b j1=%h j2=%h dv=%b busy=%b irq=%b required 1 0 ffff ffff 0 0 0",
                     snes_clock, snes_latch, joy1_data, joy2_data, data_valid, busy, change_irq);
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || rise_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_quiet got busy=%b rises=%0d required 0 0", busy, rise_q.size());
        end
    endtask

    task automatic test_single_poll();
        int f0, h0, n0, c;
        exp_t e;
        f0 = falls;
        h0 = latch_hi;
        n0 = rise_q.size();
        start_poll(16'hFFFE, 16'hF7FF);
        wait_rise(n0, c);
        wait_cyc(c + TXN - 1);
        vectors++;
        if ({joy1_data, data_valid, busy} !== {16'hFFFF, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_pre_done got j1=%h dv=%b busy=%b required ffff 0 1", joy1_data, data_valid, busy);
        end
        wait_cyc(c + TXN);
        e = sb_q.pop_front();
        vectors++;
        if ({joy1_data, joy2_data, change_irq} !== {e.j1, e.j2, e.irq}) begin
            miscompares++;
            $display("FAIL single_words got %h %h irq=%b required %h %h irq=%b",
                     joy1_data, joy2_data, change_irq, e.j1, e.j2, e.irq);
        end
        vectors++;
        if ({data_valid, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_flags got dv=%b busy=%b required dv=1 busy=0", data_valid, busy);
        end
        vectors++;
        if (falls - f0 != 16) begin
            miscompares++;
            $display("FAIL single_falling_edges got %0d required 16", falls - f0);
        end
        vectors++;
        if (latch_hi - h0 != 2 * H) begin
            miscompares++;
            $display("FAIL single_latch_width got %0d required %0d", latch_hi - h0, 2 * H);
        end
    endtask

    task automatic test_irq();
        int n0, c;
        exp_t e;
        ack_irq();
        vectors++;
        if (change_irq !== m_irq) begin
            miscompares++;
            $display("FAIL irq_ack_clear got %b required %b", change_irq, m_irq);
        end
        start_poll(ctrl1_word, ctrl2_word);
        wait_idle("irq_same");
        e = sb_q.pop_front();
        vectors++;
        if ({joy1_data, joy2_data, change_irq} !== {e.j1, e.j2, e.irq}) begin
            miscompares++;
            $display("FAIL irq_same_data got %h %h irq=%b required %h %h irq=%b",
                     joy1_data, joy2_data, change_irq, e.j1, e.j2, e.irq);
        end
        n0 = rise_q.size();
        start_poll(16'hFFFD, 16'hF7FF);
        wait_rise(n0, c);
        wait_cyc(c + TXN - 1);
        irq_ack = 1'b1;
        @(negedge clock);
        irq_ack = 1'b0;
        e = sb_q.pop_front();
        vectors++;
        if ({joy1_data, joy2_data, change_irq} !== {e.j1, e.j2, e.irq}) begin
            miscompares++;
            $display("FAIL irq_set_beats_ack got %h %h irq=%b required %h %h irq=%b",
                     joy1_data, joy2_data, change_irq, e.j1, e.j2, e.irq);
        end
        ack_irq();
    endtask

    task automatic test_back_to_back();
        int n0, c, c2;
        exp_t e, e2;
        n0 = rise_q.size();
        start_poll(16'hA5A5, 16'h5A5A);
        e2.j1  = 16'hA5A5;
        e2.j2  = 16'h5A5A;
        e2.irq = m_irq;
        sb_q.push_back(e2);
        wait_rise(n0, c);
        wait_cyc(c + 20);
        pulse_req();
        wait_cyc(c + 60);
        pulse_req();
        wait_cyc(c + 100);
        pulse_req();
        wait_idle("b2b_first");
        e = sb_q.pop_front();
        vectors++;
        if ({joy1_data, joy2_data, change_irq} !== {e.j1, e.j2, e.irq}) begin
            miscompares++;
            $display("FAIL b2b_first_words got %h %h irq=%b required %h %h irq=%b",
                     joy1_data, joy2_data, change_irq, e.j1, e.j2, e.irq);
        end
        wait_rise(n0 + 1, c2);
        vectors++;
        if (c2 != c + TXN + 1) begin
            miscompares++;
            $display("FAIL b2b_followon_start got %0d required %0d", c2, c + TXN + 1);
        end
        wait_idle("b2b_second");
        e = sb_q.pop_front();
        vectors++;
        if ({joy1_data, joy2_data, change_irq} !== {e.j1, e.j2, e.irq}) begin
            miscompares++;
            $display("FAIL b2b_second_words got %h %h irq=%b required %h %h irq=%b",
                     joy1_data, joy2_data, change_irq, e.j1, e.j2, e.irq);
        end
        repeat (400) @(negedge clock);
        vectors++;
        if (rise_q.size() != n0 + 2) begin
            miscompares++;
            $display("FAIL b2b_transaction_count got %0d required %0d", rise_q.size() - n0, 2);
        end
        ack_irq();
    endtask

    task automatic test_auto_poll();
        int n0, r0, r1, r2, r3;
        n0 = rise_q.size();
        @(negedge clock);
        auto_en = 1'b1;
        wait_rise(n0, r0);
        wait_rise(n0 + 1, r1);
        vectors++;
        if (r1 - r0 != P) begin
            miscompares++;
            $display("FAIL auto_spacing got %0d required %0d", r1 - r0, P);
        end
        // Timer strobe feeding the next latch is sampled one edge before it.
        wait_cyc(r1 + P - 2);
        poll_req = 1'b1;
        @(negedge clock);
        poll_req = 1'b0;
        wait_rise(n0 + 2, r2);
        vectors++;
        if (r2 - r1 != P) begin
            miscompares++;
            $display("FAIL auto_merged_spacing got %0d required %0d", r2 - r1, P);
        end
        wait_rise(n0 + 3, r3);
        vectors++;
        if (r3 - r2 != P) begin
            miscompares++;
            $display("FAIL auto_no_extra_txn got %0d required %0d", r3 - r2, P);
        end
        auto_en = 1'b0;
        wait_idle("auto");
        vectors++;
        if ({joy1_data, joy2_data, change_irq} !== {m_joy1, m_joy2, m_irq}) begin
            miscompares++;
            $display("FAIL auto_words got %h %h irq=%b required %h %h irq=%b",
                     joy1_data, joy2_data, change_irq, m_joy1, m_joy2, m_irq);
        end
    endtask

    task automatic test_bit_order();
        exp_t e;
        logic [15:0] w;
        for (int i = 0; i < 16; i++) begin
            w = ~(16'h0001 << i);
            start_poll(w, 16'hF7FF);
            wait_idle("bit_order");
            e = sb_q.pop_front();
            vectors++;
            if ({joy1_data, joy2_data, change_irq} !== {e.j1, e.j2, e.irq}) begin
                miscompares++;
                $display("FAIL bit_order_%0d got %h %h irq=%b required %h %h irq=%b",
                         i, joy1_data, joy2_data, change_irq, e.j1, e.j2, e.irq);
            end
            ack_irq();
        end
    endtask

    task automatic test_reset_mid_shift();
        int n0, c;
        exp_t e;
        n0 = rise_q.size();
        start_poll(16'h0F0F, 16'hF0F0);
        wait_rise(n0, c);
        wait_cyc(c + 3 * H + 14 * H + 2);
        vectors++;
        if ({snes_clock, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_shift_bit7_low got clk=%b busy=%b required clk=0 busy=1", snes_clock, busy);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({snes_clock, snes_latch, joy1_data, joy2_data, data_valid, busy, change_irq} !==
            {1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_shift_reset got clk=%b lat=%b j1=%h j2=%h dv=%b busy=%b irq=%b required 1 0 ffff ffff 0 0 0",
                     snes_clock, snes_latch, joy1_data, joy2_data, data_valid, busy, change_irq);
        end
        void'(sb_q.pop_front());
        m_joy1 = 16'hFFFF;
        m_joy2 = 16'hFFFF;
        m_irq  = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (300) @(negedge clock);
        vectors++;
        if (rise_q.size() != n0 + 1 || joy1_data !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL post_reset_quiet got rises=%0d j1=%h required 0 ffff", rise_q.size() - n0 - 1, joy1_data);
        end
        start_poll(16'h0F0F, 16'hF0F0);
        wait_idle("recover");
        e = sb_q.pop_front();
        vectors++;
        if ({joy1_data, joy2_data, change_irq, data_valid} !== {e.j1, e.j2, e.irq, 1'b1}) begin
            miscompares++;
            $display("FAIL recover_words got %h %h irq=%b dv=%b required %h %h irq=%b dv=1",
                     joy1_data, joy2_data, change_irq, data_valid, e.j1, e.j2, e.irq);
        end
    endtask

    initial begin
        test_reset();
        test_single_poll();
        test_irq();
        test_back_to_back();
        test_auto_poll();
        test_bit_order();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
